// File: rtl/asym_fifo_pkg.sv
// Shared defaults and width helpers for the asymmetric FIFO controller.
// Latency and backpressure are properties of asym_fifo_ctrl, not of this package.
package asym_fifo_pkg;

    localparam int DEF_W_DATA_W = 32;
    localparam int DEF_R_DATA_W = 8;
    localparam int DEF_ADDR_W   = 6;

    function automatic int bytesOf(input int widthBits);
        return widthBits / 8;
    endfunction

    function automatic int capOf(input int addrW);
        return 1 << addrW;
    endfunction

    // Occupancy needs one bit beyond the address so that "full" is representable.
    function automatic int levelW(input int addrW);
        return addrW + 1;
    endfunction

    function automatic bit isPow2Mult8(input int widthBits);
        int nBytes;
        nBytes = widthBits / 8;
        return (widthBits >= 8) && ((widthBits % 8) == 0) && ((nBytes & (nBytes - 1)) == 0);
    endfunction

endpackage

// File: rtl/asym_fifo_ctrl_ram.sv
// Byte-addressed dual-port RAM with independent port widths; each port accesses
// consecutive bytes from its address, little-endian. Latency 1 cycle; no backpressure.
module my_dp_asym_ram #(
    parameter int A_DATA_W = 32,
    parameter int B_DATA_W = 8,
    parameter int ADDR_W   = 6
) (
    input  logic                clk,
    input  logic                enA,
    input  logic                weA,
    input  logic [ADDR_W-1:0]   addrA,
    input  logic [A_DATA_W-1:0] dinA,
    output logic [A_DATA_W-1:0] doutA,
    input  logic                enB,
    input  logic                weB,
    input  logic [ADDR_W-1:0]   addrB,
    input  logic [B_DATA_W-1:0] dinB,
    output logic [B_DATA_W-1:0] doutB
);

    localparam int A_BYTES = A_DATA_W / 8;
    localparam int B_BYTES = B_DATA_W / 8;
    localparam int DEPTH   = 1 << ADDR_W;

    logic [7:0] mem [DEPTH];

    // Byte lanes wrap modulo DEPTH; reads return the pre-write contents.
    always_ff @(posedge clk) begin
        if (enA) begin
            if (weA) begin
                for (int i = 0; i < A_BYTES; i++) begin
                    mem[addrA + ADDR_W'(i)] <= dinA[8*i +: 8];
                end
            end else begin
                for (int i = 0; i < A_BYTES; i++) begin
                    doutA[8*i +: 8] <= mem[addrA + ADDR_W'(i)];
                end
            end
        end
        if (enB) begin
            if (weB) begin
                for (int i = 0; i < B_BYTES; i++) begin
                    mem[addrB + ADDR_W'(i)] <= dinB[8*i +: 8];
                end
            end else begin
                for (int i = 0; i < B_BYTES; i++) begin
                    doutB[8*i +: 8] <= mem[addrB + ADDR_W'(i)];
                end
            end
        end
    end

endmodule

// File: rtl/asym_fifo_ctrl.sv
// Width-converting FIFO: W_DATA_W writes on RAM port A, R_DATA_W reads on port B.
// Read latency 1 cycle; w_ready/r_ready come straight from level, rejected requests set ovf/unf.
module asym_fifo_ctrl
    import asym_fifo_pkg::*;
#(
    parameter int W_DATA_W = DEF_W_DATA_W,
    parameter int R_DATA_W = DEF_R_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                w_valid,
    output logic                w_ready,
    input  logic [W_DATA_W-1:0] w_data,
    input  logic                r_req,
    output logic                r_ready,
    output logic                r_valid,
    output logic [R_DATA_W-1:0] r_data,
    output logic [ADDR_W:0]     level,
    output logic                ovf,
    output logic                unf
);

    localparam int W_BYTES = bytesOf(W_DATA_W);
    localparam int R_BYTES = bytesOf(R_DATA_W);
    localparam int CAP     = capOf(ADDR_W);
    localparam int LVL_W   = levelW(ADDR_W);

    localparam logic [LVL_W-1:0]  W_STEP     = LVL_W'(W_BYTES);
    localparam logic [LVL_W-1:0]  R_STEP     = LVL_W'(R_BYTES);
    localparam logic [LVL_W-1:0]  W_ROOM     = LVL_W'(CAP - W_BYTES);
    localparam logic [ADDR_W-1:0] W_PTR_STEP = ADDR_W'(W_BYTES);
    localparam logic [ADDR_W-1:0] R_PTR_STEP = ADDR_W'(R_BYTES);

    if (!isPow2Mult8(W_DATA_W) || !isPow2Mult8(R_DATA_W)) begin : genBadWidth
        $error("asym_fifo_ctrl: W_DATA_W=%0d / R_DATA_W=%0d must be power-of-2 multiples of 8",
               W_DATA_W, R_DATA_W);
    end
    if (CAP < W_BYTES || CAP < R_BYTES) begin : genBadCap
        $error("asym_fifo_ctrl: capacity %0d bytes smaller than one word", CAP);
    end

    logic [ADDR_W-1:0]   wPtr;
    logic [ADDR_W-1:0]   rPtr;
    logic [LVL_W-1:0]    levelNext;
    logic                wFire;
    logic                rFire;
    logic [W_DATA_W-1:0] unusedDoutA;

    assign w_ready = (level <= W_ROOM);
    assign r_ready = (level >= R_STEP);
    assign wFire   = w_valid & w_ready;
    assign rFire   = r_req & r_ready;

    always_comb begin
        levelNext = level;
        if (wFire) levelNext = levelNext + W_STEP;
        if (rFire) levelNext = levelNext - R_STEP;
    end

    // Flush wins over any fire in the same cycle, so it must also gate the RAM enables.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wPtr    <= '0;
            rPtr    <= '0;
            level   <= '0;
            r_valid <= 1'b0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else if (flush) begin
            wPtr    <= '0;
            rPtr    <= '0;
            level   <= '0;
            r_valid <= 1'b0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else begin
            if (wFire) wPtr <= wPtr + W_PTR_STEP;
            if (rFire) rPtr <= rPtr + R_PTR_STEP;
            level   <= levelNext;
            r_valid <= rFire;
            if (w_valid && !w_ready) ovf <= 1'b1;
            if (r_req && !r_ready)   unf <= 1'b1;
        end
    end

    my_dp_asym_ram #(
        .A_DATA_W(W_DATA_W),
        .B_DATA_W(R_DATA_W),
        .ADDR_W  (ADDR_W)
    ) uRam (
        .clk  (clk),
        .enA  (wFire & ~flush),
        .weA  (1'b1),
        .addrA(wPtr),
        .dinA (w_data),
        .doutA(unusedDoutA),
        .enB  (rFire & ~flush),
        .weB  (1'b0),
        .addrB(rPtr),
        .dinB ('0),
        .doutB(r_data)
    );

endmodule
